// File: rtl/fb_scanout.sv
// fb_scanout: VGA-style timing generator that pulls RGB565 pixels from an
// upstream frame streamer into a top-left aligned window, paints a border
// colour over the rest of the active area and black during blanking.
module fb_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FB_WIDTH  = 128,
    parameter int FB_HEIGHT = 128
) (
    input  logic        clk_pix,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic [23:0] base_addr_i,
    input  logic [23:0] border_color_i,
    input  logic        err_clr_i,
    input  logic [15:0] stream_data_i,
    input  logic        stream_preloading_i,
    input  logic        stream_err_underflow_i,
    output logic        stream_start_frame_o,
    output logic [23:0] stream_base_address_o,
    output logic        stream_ena_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic [15:0] frame_count_o,
    output logic        err_underflow_o,
    output logic        err_late_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [HW-1:0] FB_W_C  = HW'(FB_WIDTH);
    localparam logic [VW-1:0] FB_H_C  = VW'(FB_HEIGHT);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_SYNC,
        ST_PRELOAD,
        ST_RUN,
        ST_SKIP
    } state_t;

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;

    // Free-running raster counters; they never stop for enable_i so the
    // monitor keeps a stable sync even while the stream is idle.
    always_comb begin
        h_cnt_next = h_cnt_reg + HW'(1);
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            if (v_cnt_reg == V_LAST) begin
                v_cnt_next = '0;
            end else begin
                v_cnt_next = v_cnt_reg + VW'(1);
            end
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    logic in_active;
    logic in_window;
    logic h_sync_pos;
    logic v_sync_pos;
    logic at_frame_start;   // first cycle of vertical blanking: request next frame
    logic at_frame_wrap;    // last cycle of the frame: next cycle is (0,0)

    assign in_active  = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
    assign in_window  = (h_cnt_reg < FB_W_C) && (v_cnt_reg < FB_H_C);
    // One extra bit so a sync pulse ending exactly at the total still compares.
    assign h_sync_pos = ({1'b0, h_cnt_reg} >= (HW+1)'(HS_START)) &&
                        ({1'b0, h_cnt_reg} <  (HW+1)'(HS_END));
    assign v_sync_pos = ({1'b0, v_cnt_reg} >= (VW+1)'(VS_START)) &&
                        ({1'b0, v_cnt_reg} <  (VW+1)'(VS_END));
    assign at_frame_start = (h_cnt_reg == '0) && (v_cnt_reg == V_ACT_C);
    assign at_frame_wrap  = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

    // ------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------
    state_t state_reg, state_next;
    logic   start_frame;
    logic   enter_run;
    logic   enter_skip;

    // Next-state and frame events. The start request is issued at the top
    // of vertical blanking so the streamer has the whole blanking interval
    // to preload; if it is still preloading when the frame wraps, the frame
    // is skipped rather than shown torn.
    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        enter_run   = 1'b0;
        enter_skip  = 1'b0;
        if (!enable_i) begin
            state_next = ST_DISABLED;
        end else begin
            case (state_reg)
                ST_DISABLED: begin
                    state_next = ST_SYNC;
                end
                ST_SYNC, ST_RUN, ST_SKIP: begin
                    if (at_frame_start) begin
                        start_frame = 1'b1;
                        state_next  = ST_PRELOAD;
                    end
                end
                ST_PRELOAD: begin
                    if (at_frame_wrap) begin
                        if (!stream_preloading_i) begin
                            enter_run  = 1'b1;
                            state_next = ST_RUN;
                        end else begin
                            enter_skip = 1'b1;
                            state_next = ST_SKIP;
                        end
                    end
                end
                default: begin
                    state_next = ST_DISABLED;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_DISABLED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pixel pull is combinational so the streamer sees it in the same cycle
    // the pixel is used; gating with enable_i makes a disable take effect
    // immediately rather than one cycle late.
    assign stream_ena_o         = enable_i && (state_reg == ST_RUN) && in_window;
    assign stream_start_frame_o = start_frame;

    // ------------------------------------------------------------------
    // Frame base address and frame counter
    // ------------------------------------------------------------------
    logic [23:0] base_addr_reg;
    logic [15:0] frame_cnt_reg;

    // Base address is captured only with the start request, so software
    // can rewrite base_addr_i at any time without tearing the current frame.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            base_addr_reg <= '0;
        end else if (start_frame) begin
            base_addr_reg <= base_addr_i;
        end
    end

    // Count frames that were actually displayed from the stream.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frame_cnt_reg <= '0;
        end else if (enter_run) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign stream_base_address_o = base_addr_reg;
    assign frame_count_o         = frame_cnt_reg;

    // ------------------------------------------------------------------
    // Sticky error flags: bit 0 underflow, bit 1 late preload
    // ------------------------------------------------------------------
    logic [1:0] err_set;
    logic [1:0] err_reg;
    logic [1:0] err_next;

    assign err_set = {enter_skip, stream_err_underflow_i};

    // A new error event wins over a clear arriving in the same cycle so
    // no event is ever lost.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err
            assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~err_clr_i);
        end
    endgenerate

    // Sticky error registers.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err_underflow_o = err_reg[0];
    assign err_late_o      = err_reg[1];

    // ------------------------------------------------------------------
    // Video output stage
    // ------------------------------------------------------------------
    logic [7:0] red_next, green_next, blue_next;
    logic [7:0] red_reg, green_reg, blue_reg;
    logic       de_reg, hsync_reg, vsync_reg;

    // Pixel colour: streamed pixels are widened by replicating their MSBs
    // so full-scale 565 maps to full-scale 888; the rest of the active
    // area shows the border colour and blanking is forced to black.
    always_comb begin
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        if (stream_ena_o) begin
            red_next   = {stream_data_i[15:11], stream_data_i[15:13]};
            green_next = {stream_data_i[10:5],  stream_data_i[10:9]};
            blue_next  = {stream_data_i[4:0],   stream_data_i[4:2]};
        end else if (in_active) begin
            red_next   = border_color_i[23:16];
            green_next = border_color_i[15:8];
            blue_next  = border_color_i[7:0];
        end
    end

    // Register all video outputs together so they stay aligned, one cycle
    // behind the raster position.
    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            de_reg    <= 1'b0;
            hsync_reg <= 1'b0;
            vsync_reg <= 1'b0;
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end else begin
            de_reg    <= in_active;
            hsync_reg <= h_sync_pos;
            vsync_reg <= v_sync_pos;
            red_reg   <= red_next;
            green_reg <= green_next;
            blue_reg  <= blue_next;
        end
    end

    assign de_o    = de_reg;
    assign hsync_o = hsync_reg;
    assign vsync_o = vsync_reg;
    assign red_o   = red_reg;
    assign green_o = green_reg;
    assign blue_o  = blue_reg;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized scoreboard bench for fb_scanout with a small
// raster (H 8/2/2/2, V 4/1/1/1, window 4x2).
module tb_fb_scanout;

    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FW = 4, FH = 2;

    // frame phases of the reference model
    localparam int M_OFF = 0, M_WAIT = 1, M_ARMED = 2, M_STREAM = 3, M_LATE = 4;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic        reset_n_i;
    logic        enable_i;
    logic [23:0] base_addr_i;
    logic [23:0] border_color_i;
    logic        err_clr_i;
    logic [15:0] stream_data_i;
    logic        stream_preloading_i;
    logic        stream_err_underflow_i;
    logic        stream_start_frame_o;
    logic [23:0] stream_base_address_o;
    logic        stream_ena_o;
    logic        hsync_o, vsync_o, de_o;
    logic [7:0]  red_o, green_o, blue_o;
    logic [15:0] frame_count_o;
    logic        err_underflow_o, err_late_o;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FB_WIDTH(FW), .FB_HEIGHT(FH)
    ) dut (
        .clk_pix(clk_pix),
        .reset_n_i(reset_n_i),
        .enable_i(enable_i),
        .base_addr_i(base_addr_i),
        .border_color_i(border_color_i),
        .err_clr_i(err_clr_i),
        .stream_data_i(stream_data_i),
        .stream_preloading_i(stream_preloading_i),
        .stream_err_underflow_i(stream_err_underflow_i),
        .stream_start_frame_o(stream_start_frame_o),
        .stream_base_address_o(stream_base_address_o),
        .stream_ena_o(stream_ena_o),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .de_o(de_o),
        .red_o(red_o),
        .green_o(green_o),
        .blue_o(blue_o),
        .frame_count_o(frame_count_o),
        .err_underflow_o(err_underflow_o),
        .err_late_o(err_late_o)
    );

    typedef struct {
        logic        start;
        logic [23:0] base;
        logic        ena;
        logic        hs, vs, de;
        logic [7:0]  r, g, b;
        logic [15:0] fc;
        logic        eu, el;
    } exp_t;

    typedef struct {
        string       name;
        int          which;
        logic [31:0] expv;
    } dchk_t;

    exp_t  sb_q[$];
    dchk_t dq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // stimulus drive values
    logic        d_rst, d_en, d_pre, d_uf, d_clr;
    logic [15:0] d_data;
    logic [23:0] d_base, d_border;
    bit          data_rand;

    // reference model state
    int   m_t;
    int   m_mode;
    exp_t m_reg;
    int   last_h, last_v;

    function automatic logic [23:0] expand565(logic [15:0] d);
        int r5, g6, b5;
        r5 = int'(d) / 2048;
        g6 = (int'(d) / 32) % 64;
        b5 = int'(d) % 32;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    // Advance the reference model by one pixel cycle using the inputs just driven.
    task automatic model_step();
        exp_t e;
        int   hc, vc;
        bit   win, at_start, at_last, late_set;
        logic [23:0] rgb;
        hc = m_t % HT;
        vc = (m_t / HT) % VT;
        last_h = hc;
        last_v = vc;
        e = m_reg;
        e.start = 1'b0;
        e.ena   = 1'b0;
        if (!d_rst) begin
            e = '{default: '0};
            sb_q.push_back(e);
            m_reg  = '{default: '0};
            m_mode = M_OFF;
            m_t    = 0;
            return;
        end
        win      = (hc < FW) && (vc < FH);
        at_start = (hc == 0) && (vc == VA);
        at_last  = (hc == HT - 1) && (vc == VT - 1);
        if (d_en) begin
            e.ena   = (m_mode == M_STREAM) && win;
            e.start = (m_mode == M_WAIT || m_mode == M_STREAM || m_mode == M_LATE) && at_start;
        end
        sb_q.push_back(e);

        m_reg.de = (hc < HA) && (vc < VA);
        m_reg.hs = (hc >= HA + HFP) && (hc < HA + HFP + HS);
        m_reg.vs = (vc >= VA + VFP) && (vc < VA + VFP + VS);
        if (e.ena)          rgb = expand565(d_data);
        else if (m_reg.de)  rgb = d_border;
        else                rgb = 24'h0;
        m_reg.r = rgb[23:16];
        m_reg.g = rgb[15:8];
        m_reg.b = rgb[7:0];
        if (e.start) m_reg.base = d_base;

        late_set = 1'b0;
        if (!d_en)                 m_mode = M_OFF;
        else if (m_mode == M_OFF)  m_mode = M_WAIT;
        else if (e.start)          m_mode = M_ARMED;
        else if (m_mode == M_ARMED && at_last) begin
            if (d_pre) begin
                m_mode   = M_LATE;
                late_set = 1'b1;
            end else begin
                m_mode   = M_STREAM;
                m_reg.fc = m_reg.fc + 16'd1;
            end
        end
        m_reg.el = late_set | (m_reg.el & ~d_clr);
        m_reg.eu = d_uf | (m_reg.eu & ~d_clr);
        m_t++;
    endtask

    // One pixel cycle: drive inputs just after the rising edge, then model it.
    task automatic tick();
        @(posedge clk_pix);
        #1;
        if (data_rand) d_data = 16'($urandom);
        reset_n_i              = d_rst;
        enable_i               = d_en;
        stream_preloading_i    = d_pre;
        stream_err_underflow_i = d_uf;
        err_clr_i              = d_clr;
        stream_data_i          = d_data;
        base_addr_i            = d_base;
        border_color_i         = d_border;
        model_step();
    endtask

    // Tick until the cycle just ticked sat at raster position (h,v).
    task automatic tick_to(input int h, input int v);
        for (int i = 0; i < HT * VT + 1; i++) begin
            tick();
            if (last_h == h && last_v == v) break;
        end
    endtask

    task automatic dcheck(input string name, input int which, input logic [31:0] expv);
        dchk_t c;
        c.name  = name;
        c.which = which;
        c.expv  = expv;
        dq.push_back(c);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expected cycle per falling edge and compares every output.
    int ena_total = 0;
    int ena_mark  = 0;
    initial begin
        exp_t  e;
        dchk_t c;
        logic [31:0] act;
        forever begin
            @(negedge clk_pix);
            if (stream_ena_o === 1'b1) ena_total++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("start_frame", 32'(stream_start_frame_o), 32'(e.start));
                cmp("base_address", 32'(stream_base_address_o), 32'(e.base));
                cmp("stream_ena", 32'(stream_ena_o), 32'(e.ena));
                cmp("hsync", 32'(hsync_o), 32'(e.hs));
                cmp("vsync", 32'(vsync_o), 32'(e.vs));
                cmp("de", 32'(de_o), 32'(e.de));
                cmp("red", 32'(red_o), 32'(e.r));
                cmp("green", 32'(green_o), 32'(e.g));
                cmp("blue", 32'(blue_o), 32'(e.b));
                cmp("frame_count", 32'(frame_count_o), 32'(e.fc));
                cmp("err_underflow", 32'(err_underflow_o), 32'(e.eu));
                cmp("err_late", 32'(err_late_o), 32'(e.el));
            end
            while (dq.size() > 0) begin
                c = dq.pop_front();
                act = 32'hDEAD_BEEF;
                case (c.which)
                    0: act = 32'(frame_count_o);
                    1: act = 32'(err_late_o);
                    2: act = 32'(err_underflow_o);
                    3: act = 32'(stream_base_address_o);
                    4: act = 32'(ena_total - ena_mark);
                    6: act = 32'(red_o);
                    7: act = 32'(green_o);
                    8: act = 32'(blue_o);
                    9: act = 32'(stream_start_frame_o);
                    default: act = 32'hDEAD_BEEF;
                endcase
                if (c.which == 5) ena_mark = ena_total;
                else cmp(c.name, act, c.expv);
            end
        end
    end

    initial begin
        d_rst = 1'b0; d_en = 1'b0; d_pre = 1'b0; d_uf = 1'b0; d_clr = 1'b0;
        d_data = 16'h0; d_base = 24'h0; d_border = 24'h0; data_rand = 1'b1;
        m_t = 0; m_mode = M_OFF; m_reg = '{default: '0}; last_h = 0; last_v = 0;
        reset_n_i = 1'b0; enable_i = 1'b0; base_addr_i = '0; border_color_i = '0;
        err_clr_i = 1'b0; stream_data_i = '0; stream_preloading_i = 1'b0;
        stream_err_underflow_i = 1'b0;

        // reset held with random inputs: everything must stay at zero
        for (int i = 0; i < 4; i++) begin
            d_en = 1'($urandom); d_pre = 1'($urandom); d_uf = 1'($urandom);
            d_base = 24'($urandom); d_border = 24'($urandom);
            tick();
        end
        $display("reset phase done");

        // enable from reset, streamer ready: one start pulse, then a 4x2 frame
        d_rst = 1'b1; d_en = 1'b1; d_pre = 1'b0; d_uf = 1'b0; d_clr = 1'b0;
        d_base = 24'h000100; d_border = 24'h123456;
        data_rand = 1'b0; d_data = 16'hF800;
        tick_to(HT - 1, VT - 1);
        dcheck("ena_mark", 5, 0);
        tick_to(HT - 1, VT - 1);
        dcheck("ena_count_run_frame", 4, 32'd8);
        dcheck("frame_count_first", 0, 32'd1);
        $display("first streamed frame done");

        // colour expansion, border and blanking
        tick_to(1, 0);
        dcheck("red_from_F800", 6, 32'hFF);
        dcheck("green_from_F800", 7, 32'h00);
        tick_to(6, 0);
        dcheck("border_red", 6, 32'h12);
        dcheck("border_green", 7, 32'h34);
        dcheck("border_blue", 8, 32'h56);
        tick_to(10, 0);
        dcheck("blank_red", 6, 32'h00);
        dcheck("blank_blue", 8, 32'h00);
        $display("colour checks done");

        // streamer still preloading at the wrap: frame skipped, late flagged
        data_rand = 1'b1;
        d_pre = 1'b1;
        tick_to(HT - 1, VT - 1);
        dcheck("ena_mark", 5, 0);
        d_pre = 1'b0;
        tick_to(HT - 1, VT - 1);
        dcheck("ena_count_skip_frame", 4, 32'd0);
        dcheck("err_late_set", 1, 32'd1);
        d_clr = 1'b1; tick(); d_clr = 1'b0; tick();
        dcheck("err_late_cleared", 1, 32'd0);
        $display("late preload phase done");

        // underflow coinciding with clear wins; a later clear alone clears
        d_uf = 1'b1; d_clr = 1'b1; tick();
        d_uf = 1'b0; d_clr = 1'b0; tick();
        dcheck("err_underflow_set_wins", 2, 32'd1);
        d_clr = 1'b1; tick(); d_clr = 1'b0; tick();
        dcheck("err_underflow_cleared", 2, 32'd0);
        $display("underflow phase done");

        // disable mid-window during a streamed frame, then re-enable
        tick_to(1, 1);
        d_en = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        d_en = 1'b1;
        tick_to(0, VA);
        dcheck("start_after_reenable", 9, 32'd1);
        dcheck("base_at_pulse_cycle", 3, 32'h000100);
        $display("disable/re-enable phase done");

        // base address rewritten mid-frame takes effect at the next start pulse
        tick_to(5, 5);
        d_base = 24'h000200;
        tick_to(0, 2);
        dcheck("base_held_mid_frame", 3, 32'h000100);
        tick_to(1, VA);
        dcheck("base_updated_after_pulse", 3, 32'h000200);
        $display("base address phase done");

        // randomized operation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) d_en = ~d_en;
            if ($urandom_range(0, 39) == 0)  d_pre = ~d_pre;
            d_uf  = ($urandom_range(0, 59) == 0);
            d_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0)  d_base = 24'($urandom);
            if ($urandom_range(0, 199) == 0) d_border = 24'($urandom);
            tick();
        end
        $display("random phase done");

        // reset in the middle of a frame, then restart cleanly
        d_en = 1'b1; d_pre = 1'b0; d_uf = 1'b0; d_clr = 1'b0;
        tick_to(3, 1);
        d_rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        d_rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d_uf = ($urandom_range(0, 79) == 0);
            tick();
        end
        $display("mid-frame reset phase done");

        // let the monitor drain what is left
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk_pix);
        @(negedge clk_pix);
        if (sb_q.size() != 0 || dq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected cycles left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
